execute_cc_mreg: RTL and testbench

- Execute-stage back end of the pipelined Y86-64 processor, directly downstream of the 64-bit ALU (add/sub/and/xor).
- Consumes the ALU result, sign and overflow to maintain the condition-code register.
- Evaluates the jump/cmov condition and produces the Execute-stage destination override.
- Holds the E->M pipeline register, with stall and bubble control, that feeds the Memory stage.

---
 rtl/execute_cc_mreg.sv | 152 +++++++++++++++
 tb/tb_execute_cc_mreg.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_cc_mreg.sv
`default_nettype none
// ============================================================================
// Module   : execute_cc_mreg
// Brief    : Y86-64 Execute back end. Holds the condition codes, evaluates
//            the jump/cmov condition and owns the E->M pipeline register.
//            Optional mispredict counter: define MISPREDICT_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module execute_cc_mreg #(
  parameter int         WIDTH = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_ifun,
  input  logic [2:0]       E_stat,
  input  logic [WIDTH-1:0] E_valA,
  input  logic [3:0]       E_dstE,
  input  logic [3:0]       E_dstM,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_sign,
  input  logic             alu_over,
  input  logic             m_exc,
  input  logic             W_exc,
  input  logic             M_stall,
  input  logic             M_bubble,
  output logic [2:0]       cc,
  output logic             e_Cnd,
  output logic [3:0]       e_dstE,
  output logic [3:0]       M_icode,
  output logic [2:0]       M_stat,
  output logic             M_Cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
`ifdef MISPREDICT_CNT_EN
  output logic [3:0]       M_dstM,
  output logic [31:0]      mispredict_cnt
`else
  output logic [3:0]       M_dstM
`endif
);

  localparam logic [3:0] C_INOP    = 4'h1;
  localparam logic [3:0] C_IRRMOVQ = 4'h2;
  localparam logic [3:0] C_IOPQ    = 4'h6;
  localparam logic [3:0] C_IJXX    = 4'h7;
  localparam logic [2:0] C_SAOK    = 3'd1;
  localparam logic [2:0] C_CC_RST  = 3'b100;

  logic [2:0]       r_cc;
  logic             w_set_cc;
  logic             w_zf;
  logic             w_sf;
  logic             w_of;
  logic             w_lt;
  logic             w_cnd;
  logic [3:0]       w_dste;
  logic             w_load;

  logic [3:0]       r_m_icode;
  logic [2:0]       r_m_stat;
  logic             r_m_cnd;
  logic [WIDTH-1:0] r_m_vale;
  logic [WIDTH-1:0] r_m_vala;
  logic [3:0]       r_m_dste;
  logic [3:0]       r_m_dstm;

  // Flags are suppressed while a later stage is excepting so the faulting
  // program state stays architecturally exact.
  assign w_set_cc = (E_icode == C_IOPQ) & ~m_exc & ~W_exc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cc <= C_CC_RST;
    end else if (w_set_cc) begin
      r_cc <= {(alu_result == '0), alu_sign, alu_over};
    end
  end

  assign w_zf = r_cc[2];
  assign w_sf = r_cc[1];
  assign w_of = r_cc[0];
  assign w_lt = w_sf ^ w_of;

  always_comb begin
    w_cnd = 1'b0;
    case (E_ifun)
      4'd0:    w_cnd = 1'b1;
      4'd1:    w_cnd = w_lt | w_zf;
      4'd2:    w_cnd = w_lt;
      4'd3:    w_cnd = w_zf;
      4'd4:    w_cnd = ~w_zf;
      4'd5:    w_cnd = ~w_lt;
      4'd6:    w_cnd = ~w_lt & ~w_zf;
      default: w_cnd = 1'b0;
    endcase
  end

  // A cmov whose condition fails must not be seen as a writer by forwarding.
  assign w_dste = ((E_icode == C_IRRMOVQ) && !w_cnd) ? RNONE : E_dstE;
  assign w_load = ~M_stall & ~M_bubble;

  always_ff @(posedge clk) begin
    if (rst || (!M_stall && M_bubble)) begin
      r_m_icode <= C_INOP;
      r_m_stat  <= C_SAOK;
      r_m_cnd   <= 1'b0;
      r_m_vale  <= '0;
      r_m_vala  <= '0;
      r_m_dste  <= RNONE;
      r_m_dstm  <= RNONE;
    end else if (w_load) begin
      r_m_icode <= E_icode;
      r_m_stat  <= E_stat;
      r_m_cnd   <= w_cnd;
      r_m_vale  <= alu_result;
      r_m_vala  <= E_valA;
      r_m_dste  <= w_dste;
      r_m_dstm  <= E_dstM;
    end
  end

`ifdef MISPREDICT_CNT_EN
  logic [31:0] r_mis_cnt;

  // Branches are predicted taken, so a failing jXX condition is a mispredict.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mis_cnt <= '0;
    end else if (w_load && (E_icode == C_IJXX) && !w_cnd && (r_mis_cnt != 32'hFFFF_FFFF)) begin
      r_mis_cnt <= r_mis_cnt + 32'd1;
    end
  end

  assign mispredict_cnt = r_mis_cnt;
`endif

  assign cc      = r_cc;
  assign e_Cnd   = w_cnd;
  assign e_dstE  = w_dste;
  assign M_icode = r_m_icode;
  assign M_stat  = r_m_stat;
  assign M_Cnd   = r_m_cnd;
  assign M_valE  = r_m_vale;
  assign M_valA  = r_m_vala;
  assign M_dstE  = r_m_dste;
  assign M_dstM  = r_m_dstm;

endmodule
`default_nettype wire

// File: tb/tb_execute_cc_mreg.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_cc_mreg
// Brief    : Scoreboard bench for execute_cc_mreg: directed plan plus random
//            traffic checked against a flag/pipeline reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_cc_mreg;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   E_icode = 4'h1;
  logic [3:0]   E_ifun = 4'h0;
  logic [2:0]   E_stat = 3'd1;
  logic [W-1:0] E_valA = '0;
  logic [3:0]   E_dstE = 4'hF;
  logic [3:0]   E_dstM = 4'hF;
  logic [W-1:0] alu_result = '0;
  logic         alu_sign = 1'b0;
  logic         alu_over = 1'b0;
  logic         m_exc = 1'b0;
  logic         W_exc = 1'b0;
  logic         M_stall = 1'b0;
  logic         M_bubble = 1'b0;

  logic [2:0]   cc;
  logic         e_Cnd;
  logic [3:0]   e_dstE;
  logic [3:0]   M_icode;
  logic [2:0]   M_stat;
  logic         M_Cnd;
  logic [W-1:0] M_valE;
  logic [W-1:0] M_valA;
  logic [3:0]   M_dstE;
  logic [3:0]   M_dstM;
  logic [31:0]  mis_cnt;

  execute_cc_mreg #(.WIDTH(W), .RNONE(4'hF)) dut (
    .clk(clk), .rst(rst),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_stat(E_stat), .E_valA(E_valA),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .alu_result(alu_result), .alu_sign(alu_sign), .alu_over(alu_over),
    .m_exc(m_exc), .W_exc(W_exc), .M_stall(M_stall), .M_bubble(M_bubble),
    .cc(cc), .e_Cnd(e_Cnd), .e_dstE(e_dstE),
    .M_icode(M_icode), .M_stat(M_stat), .M_Cnd(M_Cnd), .M_valE(M_valE),
    .M_valA(M_valA), .M_dstE(M_dstE),
`ifdef MISPREDICT_CNT_EN
    .M_dstM(M_dstM), .mispredict_cnt(mis_cnt)
`else
    .M_dstM(M_dstM)
`endif
  );

`ifndef MISPREDICT_CNT_EN
  assign mis_cnt = 32'd0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   cc;
    logic         cnd;
    logic [3:0]   dste;
    logic [3:0]   icode;
    logic [2:0]   stat;
    logic         mcnd;
    logic [W-1:0] vale;
    logic [W-1:0] vala;
    logic [3:0]   mdste;
    logic [3:0]   mdstm;
    logic [31:0]  cnt;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model state: architectural flags, M-stage contents, counter.
  bit           md_zf, md_sf, md_of;
  exp_t         md_m;
  longint unsigned md_cnt;
  bit           md_valid = 0;

  // Signed-compare outcome from the flags: "less" is SF differing from OF.
  function automatic bit take(input logic [3:0] f, input bit zf, sf, of);
    bit less;
    less = (sf != of);
    case (f)
      4'd0: return 1'b1;
      4'd1: return less || zf;
      4'd2: return less;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !less;
      4'd6: return !less && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    {md_zf, md_sf, md_of} = 3'b100;
    md_m.icode = 4'h1; md_m.stat = 3'd1; md_m.mcnd = 1'b0;
    md_m.vale = '0; md_m.vala = '0; md_m.mdste = 4'hF; md_m.mdstm = 4'hF;
    md_cnt = 0;
  endtask

  task automatic apply(input bit r, input logic [3:0] ic, fn, input logic [2:0] st,
                       input logic [W-1:0] va, input logic [3:0] de, dm,
                       input logic [W-1:0] res, input bit sg, ov, mx, wx, stl, bub);
    exp_t e;
    bit c;
    @(posedge clk);
    #2;
    rst = r; E_icode = ic; E_ifun = fn; E_stat = st; E_valA = va;
    E_dstE = de; E_dstM = dm; alu_result = res; alu_sign = sg; alu_over = ov;
    m_exc = mx; W_exc = wx; M_stall = stl; M_bubble = bub;
    c = take(fn, md_zf, md_sf, md_of);
    if (md_valid) begin
      e = md_m;
      e.cc = {md_zf, md_sf, md_of};
      e.cnd = c;
      e.dste = (ic == 4'h2 && !c) ? 4'hF : de;
      e.cnt = md_cnt[31:0];
      q.push_back(e);
    end
    if (r) begin
      model_reset();
      md_valid = 1;
    end else begin
      if (ic == 4'h6 && !mx && !wx) begin
        md_zf = (res == 0); md_sf = sg; md_of = ov;
      end
      if (!stl && bub) begin
        md_m.icode = 4'h1; md_m.stat = 3'd1; md_m.mcnd = 1'b0;
        md_m.vale = '0; md_m.vala = '0; md_m.mdste = 4'hF; md_m.mdstm = 4'hF;
      end else if (!stl) begin
        md_m.icode = ic; md_m.stat = st; md_m.mcnd = c; md_m.vale = res;
        md_m.vala = va; md_m.mdste = (ic == 4'h2 && !c) ? 4'hF : de; md_m.mdstm = dm;
        if (ic == 4'h7 && !c && md_cnt < 64'hFFFF_FFFF) md_cnt++;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cc", W'(cc), W'(e.cc));
        chk("e_Cnd", W'(e_Cnd), W'(e.cnd));
        chk("e_dstE", W'(e_dstE), W'(e.dste));
        chk("M_icode", W'(M_icode), W'(e.icode));
        chk("M_stat", W'(M_stat), W'(e.stat));
        chk("M_Cnd", W'(M_Cnd), W'(e.mcnd));
        chk("M_valE", M_valE, e.vale);
        chk("M_valA", M_valA, e.vala);
        chk("M_dstE", W'(M_dstE), W'(e.mdste));
        chk("M_dstM", W'(M_dstM), W'(e.mdstm));
`ifdef MISPREDICT_CNT_EN
        chk("mispredict_cnt", W'(mis_cnt), W'(e.cnt));
`endif
      end
    end
  end

  initial begin : driver
    logic [3:0] ic;
    logic [W-1:0] res;
    // Reset, then an idle cycle so the reset state itself is observed.
    apply(1, 4'h1, 4'h0, 3'd1, '0, 4'hF, 4'hF, '0, 0, 0, 0, 0, 0, 0);
    apply(0, 4'h1, 4'h0, 3'd1, '0, 4'hF, 4'hF, '0, 0, 0, 0, 0, 1, 0);
    // OPq giving zero, then overflowing negative, then a masked OPq.
    apply(0, 4'h6, 4'h1, 3'd1, 64'd7, 4'h2, 4'hF, '0, 0, 0, 0, 0, 0, 0);
    apply(0, 4'h6, 4'h0, 3'd1, 64'd1, 4'h3, 4'hF, 64'h8000_0000_0000_0000, 1, 1, 0, 0, 0, 0);
    apply(0, 4'h6, 4'h0, 3'd1, 64'd2, 4'h4, 4'hF, 64'd5, 0, 0, 1, 0, 0, 0);
    apply(0, 4'h6, 4'h0, 3'd1, 64'd2, 4'h4, 4'hF, 64'd0, 0, 0, 0, 1, 0, 0);
    // cc = SF only: cmovl moves, cmovge squashes.
    apply(0, 4'h6, 4'h1, 3'd1, 64'd3, 4'h5, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0, 0, 0);
    apply(0, 4'h2, 4'h2, 3'd1, 64'd9, 4'h3, 4'hF, 64'd9, 0, 0, 0, 0, 0, 0);
    apply(0, 4'h2, 4'h5, 3'd1, 64'd9, 4'h3, 4'hF, 64'd9, 0, 0, 0, 0, 0, 0);
    // Stall twice with changing inputs, stall+bubble, bubble alone.
    apply(0, 4'h3, 4'h0, 3'd2, 64'd11, 4'h6, 4'h7, 64'd12, 0, 0, 0, 0, 1, 0);
    apply(0, 4'h5, 4'h0, 3'd3, 64'd13, 4'h8, 4'h9, 64'd14, 0, 0, 0, 0, 1, 0);
    apply(0, 4'h4, 4'h0, 3'd4, 64'd15, 4'hA, 4'hB, 64'd16, 0, 0, 0, 0, 1, 1);
    apply(0, 4'h4, 4'h0, 3'd1, 64'd17, 4'hA, 4'hB, 64'd18, 0, 0, 0, 0, 0, 1);
    // cc = 000, then three jle (one stalled): two mispredicts.
    apply(0, 4'h6, 4'h0, 3'd1, 64'd0, 4'h1, 4'hF, 64'd1, 0, 0, 0, 0, 0, 0);
    apply(0, 4'h7, 4'h1, 3'd1, 64'd0, 4'hF, 4'hF, 64'h40, 0, 0, 0, 0, 0, 0);
    apply(0, 4'h7, 4'h1, 3'd1, 64'd0, 4'hF, 4'hF, 64'h50, 0, 0, 0, 0, 1, 0);
    apply(0, 4'h7, 4'h1, 3'd1, 64'd0, 4'hF, 4'hF, 64'h60, 0, 0, 0, 0, 0, 0);
    apply(0, 4'h1, 4'h0, 3'd1, 64'd0, 4'hF, 4'hF, 64'h0, 0, 0, 0, 0, 0, 0);
    // Random traffic biased toward OPq / cmov / jXX.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    ic = 4'h6;
        2:       ic = 4'h2;
        3:       ic = 4'h7;
        default: ic = 4'($urandom_range(0, 15));
      endcase
      res = ($urandom_range(0, 4) == 0) ? '0 : {$urandom, $urandom};
      apply($urandom_range(0, 99) == 0, ic, 4'($urandom_range(0, 8)),
            3'($urandom_range(1, 4)), {$urandom, $urandom},
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), res,
            res[W-1], $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
